window_position_ctrl: RTL and testbench

- Parametrised controller for the position of the drawable window (character/sprite region) inside the VGA active area.
- Replaces the fixed-step, wrap-only offset logic. Adds pixel-granular step, three edge modes (wrap, clamp, bounce), and button edge detection. Holding a button moves the window once.
- Bounce mode drives the window automatically from a programmable tick divider.
- Outputs feed the pixel-generator start/end compares directly.

---
 rtl/window_position_ctrl.sv | 253 +++++++++++++++++++++++++
 tb/tb_window_position_ctrl.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/window_position_ctrl.sv
// window_position_ctrl
//   Positions the drawable window (sprite/character region) inside the VGA
//   active area. Button presses act on their rising edge only. Edge handling
//   is wrap, clamp or bounce; bounce mode moves the window automatically on a
//   programmable tick.
//
// Ports
//   clock          pixel clock
//   reset          asynchronous active-high reset, recentres the window
//   moveDirection  {Right, Left, Down, Up} level requests, rising edge acts
//   moveStep       move distance per event (pixels / lines)
//   edgeMode       00 wrap, 01 clamp, 10 bounce, 11 clamp
//   tickDiv        bounce tick period minus one
//   recenter       synchronous recentre request
//   posHorStart/End, posVerStart/End   registered window bounds
//   atEdge         {right, left, bottom, top} boundary flags (combinational)
//   moving         one-cycle pulse after any start-register change
module window_position_ctrl #(
   parameter int HDR    = 640,
   parameter int VDR    = 480,
   parameter int HAL    = 64,
   parameter int VAL    = 48,
   parameter int HW     = 10,
   parameter int VW     = 9,
   parameter int STEP_W = 4,
   parameter int DIV_W  = 20
) (
   input  logic              clock,
   input  logic              reset,
   input  logic [3:0]        moveDirection,
   input  logic [STEP_W-1:0] moveStep,
   input  logic [1:0]        edgeMode,
   input  logic [DIV_W-1:0]  tickDiv,
   input  logic              recenter,
   output logic [HW-1:0]     posHorStart,
   output logic [HW-1:0]     posHorEnd,
   output logic [VW-1:0]     posVerStart,
   output logic [VW-1:0]     posVerEnd,
   output logic [3:0]        atEdge,
   output logic              moving
);

   // One spare bit over the wider axis so sums never truncate before compares.
   localparam int CW = ((HW > VW) ? HW : VW) + 1;

   localparam logic [CW-1:0] H_DR  = CW'(HDR);
   localparam logic [CW-1:0] V_DR  = CW'(VDR);
   localparam logic [CW-1:0] H_AL  = CW'(HAL);
   localparam logic [CW-1:0] V_AL  = CW'(VAL);
   localparam logic [CW-1:0] H_MAX = CW'(HDR - HAL);
   localparam logic [CW-1:0] V_MAX = CW'(VDR - VAL);
   localparam logic [CW-1:0] H_CTR = CW'((HDR - HAL) / 2);
   localparam logic [CW-1:0] V_CTR = CW'((VDR - VAL) / 2);

   // Modular step: result stays in [0, dr).
   function automatic logic [CW-1:0] wrap_step(input logic [CW-1:0] start,
                                               input logic [CW-1:0] step,
                                               input logic [CW-1:0] dr,
                                               input logic          up);
      logic [CW-1:0] res;
      if (up) begin
         if (start + step >= dr) res = start + step - dr;
         else                    res = start + step;
      end else begin
         if (start < step) res = dr + start - step;
         else              res = start - step;
      end
      return res;
   endfunction

   // Saturating step: result stays in [0, maxv], even if start was outside.
   function automatic logic [CW-1:0] clamp_step(input logic [CW-1:0] start,
                                                input logic [CW-1:0] step,
                                                input logic [CW-1:0] maxv,
                                                input logic          up);
      logic [CW-1:0] res;
      if (up) begin
         if (start + step >= maxv) res = maxv;
         else                      res = start + step;
      end else begin
         if (start < step)             res = {CW{1'b0}};
         else if (start - step > maxv) res = maxv;
         else                          res = start - step;
      end
      return res;
   endfunction

   // True when a bounce step reaches or passes its bound (landing counts).
   function automatic logic hits_bound(input logic [CW-1:0] start,
                                       input logic [CW-1:0] step,
                                       input logic [CW-1:0] maxv,
                                       input logic          up);
      logic hit;
      if (up) hit = (start + step >= maxv);
      else    hit = (start <= step);
      return hit;
   endfunction

   // Window end column/line; wraps only when the start sits near the far edge.
   function automatic logic [CW-1:0] end_of(input logic [CW-1:0] start,
                                            input logic [CW-1:0] al,
                                            input logic [CW-1:0] dr);
      logic [CW-1:0] s;
      s = start + al - CW'(1);
      if (s < dr) return s;
      else        return s - dr;
   endfunction

   logic [3:0]       dir_prev_r;
   logic             dir_h_r;      // 1 = right
   logic             dir_v_r;      // 1 = down
   logic [DIV_W-1:0] cnt_r;
   logic [1:0]       mode_prev_r;
   logic             mode_vld_r;   // mode_prev_r holds a real sample

   logic [3:0]       evt_s;
   logic             h_plus_s, h_minus_s, v_plus_s, v_minus_s;
   logic [CW-1:0]    step_s;
   logic             step_nz_s;
   logic             bounce_s;
   logic             mode_chg_s;
   logic             tick_s;
   logic [CW-1:0]    h_cur_s, v_cur_s;
   logic [CW-1:0]    h_nxt_s, v_nxt_s;
   logic             dir_h_nxt_s, dir_v_nxt_s;
   logic [DIV_W-1:0] cnt_nxt_s;
   logic [CW-1:0]    h_end_s, v_end_s;
   logic             moving_nxt_s;

   assign evt_s      = moveDirection & ~dir_prev_r;
   // Opposing presses on one axis cancel each other.
   assign h_plus_s   = evt_s[3] & ~evt_s[2];
   assign h_minus_s  = evt_s[2] & ~evt_s[3];
   assign v_plus_s   = evt_s[1] & ~evt_s[0];
   assign v_minus_s  = evt_s[0] & ~evt_s[1];
   assign step_s     = CW'(moveStep);
   assign step_nz_s  = (moveStep != {STEP_W{1'b0}});
   assign bounce_s   = (edgeMode == 2'b10);
   assign mode_chg_s = mode_vld_r & (edgeMode != mode_prev_r);
   // >= rather than == so a tickDiv lowered below the count still ticks.
   assign tick_s     = bounce_s & ~mode_chg_s & (cnt_r >= tickDiv);
   assign h_cur_s    = CW'(posHorStart);
   assign v_cur_s    = CW'(posVerStart);

   // Bounce tick divider; idle at zero outside bounce and on a mode change.
   always_comb begin
      cnt_nxt_s = {DIV_W{1'b0}};
      if (!bounce_s || mode_chg_s) cnt_nxt_s = {DIV_W{1'b0}};
      else if (tick_s)             cnt_nxt_s = {DIV_W{1'b0}};
      else                         cnt_nxt_s = cnt_r + DIV_W'(1);
   end

   // Next start positions and bounce directions.
   always_comb begin
      h_nxt_s     = h_cur_s;
      v_nxt_s     = v_cur_s;
      dir_h_nxt_s = dir_h_r;
      dir_v_nxt_s = dir_v_r;
      if (recenter) begin
         h_nxt_s = H_CTR;
         v_nxt_s = V_CTR;
      end else if (mode_chg_s) begin
         h_nxt_s = h_cur_s;
         v_nxt_s = v_cur_s;
      end else begin
         case (edgeMode)
            2'b00: begin
               if (step_nz_s && (h_plus_s || h_minus_s))
                  h_nxt_s = wrap_step(h_cur_s, step_s, H_DR, h_plus_s);
               else
                  h_nxt_s = h_cur_s;
               if (step_nz_s && (v_plus_s || v_minus_s))
                  v_nxt_s = wrap_step(v_cur_s, step_s, V_DR, v_plus_s);
               else
                  v_nxt_s = v_cur_s;
            end
            2'b10: begin
               // A press only steers its axis; the move comes on a later tick.
               if (h_plus_s || h_minus_s) begin
                  dir_h_nxt_s = h_plus_s;
               end else if (tick_s && step_nz_s) begin
                  h_nxt_s = clamp_step(h_cur_s, step_s, H_MAX, dir_h_r);
                  if (hits_bound(h_cur_s, step_s, H_MAX, dir_h_r)) dir_h_nxt_s = ~dir_h_r;
                  else                                             dir_h_nxt_s = dir_h_r;
               end else begin
                  h_nxt_s = h_cur_s;
               end
               if (v_plus_s || v_minus_s) begin
                  dir_v_nxt_s = v_plus_s;
               end else if (tick_s && step_nz_s) begin
                  v_nxt_s = clamp_step(v_cur_s, step_s, V_MAX, dir_v_r);
                  if (hits_bound(v_cur_s, step_s, V_MAX, dir_v_r)) dir_v_nxt_s = ~dir_v_r;
                  else                                             dir_v_nxt_s = dir_v_r;
               end else begin
                  v_nxt_s = v_cur_s;
               end
            end
            default: begin
               if (step_nz_s && (h_plus_s || h_minus_s))
                  h_nxt_s = clamp_step(h_cur_s, step_s, H_MAX, h_plus_s);
               else
                  h_nxt_s = h_cur_s;
               if (step_nz_s && (v_plus_s || v_minus_s))
                  v_nxt_s = clamp_step(v_cur_s, step_s, V_MAX, v_plus_s);
               else
                  v_nxt_s = v_cur_s;
            end
         endcase
      end
   end

   assign h_end_s      = end_of(h_nxt_s, H_AL, H_DR);
   assign v_end_s      = end_of(v_nxt_s, V_AL, V_DR);
   assign moving_nxt_s = (h_nxt_s != h_cur_s) | (v_nxt_s != v_cur_s);

   // State and registered outputs.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         posHorStart <= HW'(H_CTR);
         posHorEnd   <= HW'(H_CTR + H_AL - CW'(1));
         posVerStart <= VW'(V_CTR);
         posVerEnd   <= VW'(V_CTR + V_AL - CW'(1));
         dir_prev_r  <= 4'b0000;
         dir_h_r     <= 1'b1;
         dir_v_r     <= 1'b1;
         cnt_r       <= {DIV_W{1'b0}};
         mode_prev_r <= 2'b00;
         mode_vld_r  <= 1'b0;
         moving      <= 1'b0;
      end else begin
         posHorStart <= HW'(h_nxt_s);
         posHorEnd   <= HW'(h_end_s);
         posVerStart <= VW'(v_nxt_s);
         posVerEnd   <= VW'(v_end_s);
         dir_prev_r  <= moveDirection;
         dir_h_r     <= dir_h_nxt_s;
         dir_v_r     <= dir_v_nxt_s;
         cnt_r       <= cnt_nxt_s;
         mode_prev_r <= edgeMode;
         mode_vld_r  <= 1'b1;
         moving      <= moving_nxt_s;
      end
   end

   // Boundary flags straight from the start registers.
   always_comb begin
      atEdge[3] = (posHorStart == HW'(H_MAX));
      atEdge[2] = (posHorStart == {HW{1'b0}});
      atEdge[1] = (posVerStart == VW'(V_MAX));
      atEdge[0] = (posVerStart == {VW{1'b0}});
   end

endmodule

// File: tb/tb_window_position_ctrl.sv
module tb_window_position_ctrl;

   logic        clock = 1'b0;
   logic        reset;
   logic [3:0]  moveDirection;
   logic [3:0]  moveStep;
   logic [1:0]  edgeMode;
   logic [19:0] tickDiv;
   logic        recenter;
   logic [9:0]  posHorStart, posHorEnd;
   logic [8:0]  posVerStart, posVerEnd;
   logic [3:0]  atEdge;
   logic        moving;

   int checks = 0;
   int errors = 0;

   window_position_ctrl dut (
      .clock(clock), .reset(reset), .moveDirection(moveDirection),
      .moveStep(moveStep), .edgeMode(edgeMode), .tickDiv(tickDiv),
      .recenter(recenter), .posHorStart(posHorStart), .posHorEnd(posHorEnd),
      .posVerStart(posVerStart), .posVerEnd(posVerEnd), .atEdge(atEdge),
      .moving(moving)
   );

   always #5 clock = ~clock;

   // advance one edge and sample just after it
   task automatic cycle();
      @(posedge clock);
      #1;
   endtask

   // release all buttons for one edge, then press dir on the next
   task automatic pulse(input logic [3:0] dir);
      moveDirection = 4'b0000;
      cycle();
      moveDirection = dir;
      cycle();
   endtask

   task automatic do_recenter();
      moveDirection = 4'b0000;
      recenter = 1'b1;
      cycle();
      recenter = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b1; moveDirection = 4'b0000; moveStep = 4'd15;
      edgeMode = 2'b00; tickDiv = 20'd0; recenter = 1'b0;
      #23;
      checks++; if (posHorStart !== 10'd288) begin errors++; $display("FAIL reset_hs got %0d exp 288", posHorStart); end
      checks++; if (posHorEnd !== 10'd351) begin errors++; $display("FAIL reset_he got %0d exp 351", posHorEnd); end
      checks++; if (posVerStart !== 9'd216) begin errors++; $display("FAIL reset_vs got %0d exp 216", posVerStart); end
      checks++; if (posVerEnd !== 9'd263) begin errors++; $display("FAIL reset_ve got %0d exp 263", posVerEnd); end
      checks++; if (atEdge !== 4'b0000) begin errors++; $display("FAIL reset_edge got %b exp 0000", atEdge); end
      checks++; if (moving !== 1'b0) begin errors++; $display("FAIL reset_moving got %b exp 0", moving); end
      reset = 1'b0;
      cycle();
   endtask

   task automatic test_wrap();
      int exp_hs;
      edgeMode = 2'b00; moveStep = 4'd15;
      exp_hs = 288;
      for (int i = 0; i < 5; i++) begin
         pulse(4'b0100);
         exp_hs = exp_hs - 15;
         checks++; if (posHorStart !== 10'(exp_hs)) begin errors++; $display("FAIL wrap_left%0d got %0d exp %0d", i, posHorStart, exp_hs); end
         checks++; if (moving !== 1'b1) begin errors++; $display("FAIL wrap_moving%0d got %b exp 1", i, moving); end
      end
      // clamp down to 0: 213 -> 3 after 14 steps, then 0
      edgeMode = 2'b01;
      for (int i = 0; i < 15; i++) pulse(4'b0100);
      checks++; if (posHorStart !== 10'd0) begin errors++; $display("FAIL clamp_left_zero got %0d exp 0", posHorStart); end
      checks++; if (atEdge !== 4'b0100) begin errors++; $display("FAIL edge_left got %b exp 0100", atEdge); end
      edgeMode = 2'b00; moveStep = 4'd10;
      pulse(4'b1000);
      checks++; if (posHorStart !== 10'd10) begin errors++; $display("FAIL wrap_right10 got %0d exp 10", posHorStart); end
      moveStep = 4'd15;
      pulse(4'b0100);
      checks++; if (posHorStart !== 10'd635) begin errors++; $display("FAIL wrap_under_hs got %0d exp 635", posHorStart); end
      checks++; if (posHorEnd !== 10'd58) begin errors++; $display("FAIL wrap_under_he got %0d exp 58", posHorEnd); end
      checks++; if (atEdge !== 4'b0000) begin errors++; $display("FAIL wrap_under_edge got %b exp 0000", atEdge); end
   endtask

   task automatic test_clamp();
      edgeMode = 2'b01; moveStep = 4'd15;
      do_recenter();
      checks++; if (posHorStart !== 10'd288) begin errors++; $display("FAIL recenter_hs got %0d exp 288", posHorStart); end
      checks++; if (moving !== 1'b1) begin errors++; $display("FAIL recenter_moving got %b exp 1", moving); end
      for (int i = 0; i < 19; i++) pulse(4'b1000);
      checks++; if (posHorStart !== 10'd573) begin errors++; $display("FAIL clamp_573 got %0d exp 573", posHorStart); end
      pulse(4'b1000);
      checks++; if (posHorStart !== 10'd576) begin errors++; $display("FAIL clamp_576 got %0d exp 576", posHorStart); end
      checks++; if (posHorEnd !== 10'd639) begin errors++; $display("FAIL clamp_end got %0d exp 639", posHorEnd); end
      checks++; if (atEdge[3] !== 1'b1) begin errors++; $display("FAIL clamp_edge_right got %b exp 1", atEdge[3]); end
      pulse(4'b1000);
      checks++; if (moving !== 1'b0) begin errors++; $display("FAIL clamp_hold_moving got %b exp 0", moving); end
      checks++; if (posHorStart !== 10'd576) begin errors++; $display("FAIL clamp_hold got %0d exp 576", posHorStart); end
   endtask

   task automatic test_hold_and_opposing();
      int moves;
      edgeMode = 2'b00; moveStep = 4'd8;
      do_recenter();
      cycle();
      moves = 0;
      moveDirection = 4'b0100;
      for (int i = 0; i < 10; i++) begin
         cycle();
         if (moving === 1'b1) moves++;
      end
      checks++; if (moves !== 1) begin errors++; $display("FAIL held_button_moves got %0d exp 1", moves); end
      checks++; if (posHorStart !== 10'd280) begin errors++; $display("FAIL held_button_hs got %0d exp 280", posHorStart); end
      pulse(4'b1110);
      checks++; if (posHorStart !== 10'd280) begin errors++; $display("FAIL opposing_hs got %0d exp 280", posHorStart); end
      checks++; if (posVerStart !== 9'd224) begin errors++; $display("FAIL opposing_vs got %0d exp 224", posVerStart); end
      checks++; if (moving !== 1'b1) begin errors++; $display("FAIL opposing_moving got %b exp 1", moving); end
      moveDirection = 4'b0000;
   endtask

   task automatic test_bounce();
      int hq[$], vq[$], cq[$];
      logic [3:0] aq[$];
      tickDiv = 20'd3; moveStep = 4'd8; edgeMode = 2'b10;
      for (int i = 0; i < 170; i++) begin
         cycle();
         if (moving === 1'b1) begin
            hq.push_back(int'(posHorStart));
            vq.push_back(int'(posVerStart));
            aq.push_back(atEdge);
            cq.push_back(i);
         end
      end
      checks++;
      if (vq.size() < 38) begin
         errors++; $display("FAIL bounce_tick_count got %0d exp >=38", vq.size());
      end else begin
         checks++; if (vq[0] !== 232) begin errors++; $display("FAIL bounce_v_first got %0d exp 232", vq[0]); end
         checks++; if (hq[0] !== 288) begin errors++; $display("FAIL bounce_h_first got %0d exp 288", hq[0]); end
         checks++; if (cq[1] - cq[0] !== 4) begin errors++; $display("FAIL bounce_period got %0d exp 4", cq[1] - cq[0]); end
         checks++; if (vq[25] !== 432) begin errors++; $display("FAIL bounce_v_peak got %0d exp 432", vq[25]); end
         checks++; if (aq[25] !== 4'b0010) begin errors++; $display("FAIL bounce_edge_bottom got %b exp 0010", aq[25]); end
         checks++; if (vq[26] !== 424) begin errors++; $display("FAIL bounce_v_return got %0d exp 424", vq[26]); end
         checks++; if (hq[36] !== 576) begin errors++; $display("FAIL bounce_h_peak got %0d exp 576", hq[36]); end
         checks++; if (aq[36] !== 4'b1000) begin errors++; $display("FAIL bounce_edge_right got %b exp 1000", aq[36]); end
         checks++; if (hq[37] !== 568) begin errors++; $display("FAIL bounce_h_return got %0d exp 568", hq[37]); end
      end
   endtask

   task automatic test_recenter_and_async_reset();
      int n;
      recenter = 1'b1; moveDirection = 4'b0100;
      cycle();
      checks++; if (posHorStart !== 10'd288) begin errors++; $display("FAIL rc_hs got %0d exp 288", posHorStart); end
      checks++; if (posVerStart !== 9'd216) begin errors++; $display("FAIL rc_vs got %0d exp 216", posVerStart); end
      checks++; if (moving !== 1'b1) begin errors++; $display("FAIL rc_moving got %b exp 1", moving); end
      recenter = 1'b0; moveDirection = 4'b0000;
      for (int i = 0; i < 6; i++) cycle();
      #2 reset = 1'b1;
      #1;
      checks++; if (posHorStart !== 10'd288 || posHorEnd !== 10'd351) begin errors++; $display("FAIL async_h got %0d/%0d exp 288/351", posHorStart, posHorEnd); end
      checks++; if (posVerStart !== 9'd216 || posVerEnd !== 9'd263) begin errors++; $display("FAIL async_v got %0d/%0d exp 216/263", posVerStart, posVerEnd); end
      checks++; if (moving !== 1'b0) begin errors++; $display("FAIL async_moving got %b exp 0", moving); end
      #2 reset = 1'b0;
      n = 0;
      for (int i = 0; i < 20; i++) begin
         cycle();
         n++;
         if (moving === 1'b1) break;
      end
      checks++; if (n !== 4) begin errors++; $display("FAIL restart_edges got %0d exp 4", n); end
      checks++; if (posVerStart !== 9'd224) begin errors++; $display("FAIL restart_vs got %0d exp 224", posVerStart); end
      checks++; if (posHorStart !== 10'd296) begin errors++; $display("FAIL restart_hs got %0d exp 296", posHorStart); end
   endtask

   initial begin
      test_reset();
      test_wrap();
      test_clamp();
      test_hold_and_opposing();
      test_bounce();
      test_recenter_and_async_reset();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
